// File: rtl/atm_session_guard.sv
// Card-session guard that drives the inactivity timer and escalates repeated timeouts to an abort.
// Optional macro ATM_SESSION_GUARD_ABORT_COUNT_EN adds an 8-bit saturating abort_count output.
module atm_session_guard #(
   parameter logic [1:0] WARN_LIMIT = 2'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       card_in,
   input  logic       key_valid,
   input  logic       session_done,
   input  logic       timeout,
   output logic       tmr_start,
   output logic       tmr_restart,
   output logic       session_active,
   output logic       warn,
   output logic       session_abort,
   output logic       eject_req
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
   ,
   output logic [7:0] abort_count
`endif
);

   typedef enum logic [2:0] {
      StIdle,
      StActive,
      StRearm,
      StWarn,
      StAbort,
      StEjectWait
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] warn_cnt_q, warn_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         warn_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         warn_cnt_q <= warn_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      warn_cnt_d = warn_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (card_in) begin
               state_d    = StActive;
               warn_cnt_d = 2'd0;
            end
         end
         StActive, StWarn: begin
            if (!card_in || session_done) begin
               state_d = StIdle;
            end else if (timeout) begin
               // Timeout beats a same-cycle keypress: the timer has already fired.
               if (warn_cnt_q == WARN_LIMIT) begin
                  state_d = StAbort;
               end else begin
                  state_d    = StRearm;
                  warn_cnt_d = warn_cnt_q + 2'd1;
               end
            end else if (key_valid && (state_q == StWarn)) begin
               state_d    = StActive;
               warn_cnt_d = 2'd0;
            end
         end
         StRearm:     state_d = card_in ? StWarn : StIdle;
         StAbort:     state_d = StEjectWait;
         StEjectWait: if (!card_in) state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      tmr_start      = (state_q == StActive) || (state_q == StWarn);
      tmr_restart    = key_valid && tmr_start;
      session_active = (state_q == StActive) || (state_q == StRearm) || (state_q == StWarn);
      warn           = (state_q == StWarn);
      session_abort  = (state_q == StAbort);
      eject_req      = (state_q == StEjectWait);
   end

`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
   logic [7:0] abort_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         abort_cnt_q <= 8'd0;
      end else if ((state_d == StAbort) && (state_q != StAbort) && (abort_cnt_q != 8'hFF)) begin
         abort_cnt_q <= abort_cnt_q + 8'd1;
      end
   end

   assign abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_atm_session_guard.sv
// Directed bench for atm_session_guard; three instances cover WARN_LIMIT = 1, 0 and 2.
module tb_atm_session_guard;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic card_in = 1'b0, key_valid = 1'b0, session_done = 1'b0, timeout = 1'b0;
   // {tmr_start, tmr_restart, session_active, warn, session_abort, eject_req}
   logic [5:0] o1, o0, o2;
   int total = 0;
   int bad = 0;

   localparam logic [5:0] IDLE = 6'b000000, ACT = 6'b101000, ACT_K = 6'b111000;
   localparam logic [5:0] REARM = 6'b001000, WARN = 6'b101100, WARN_K = 6'b111100;
   localparam logic [5:0] ABRT = 6'b000010, EJCT = 6'b000001;

`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
   logic [7:0] cnt1, cnt0, cnt2;
`endif

   always #5 clk = ~clk;

   atm_session_guard #(.WARN_LIMIT(2'd1)) dut1 (
      .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid),
      .session_done(session_done), .timeout(timeout),
      .tmr_start(o1[5]), .tmr_restart(o1[4]), .session_active(o1[3]), .warn(o1[2]),
      .session_abort(o1[1]), .eject_req(o1[0])
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
      , .abort_count(cnt1)
`endif
   );

   atm_session_guard #(.WARN_LIMIT(2'd0)) dut0 (
      .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid),
      .session_done(session_done), .timeout(timeout),
      .tmr_start(o0[5]), .tmr_restart(o0[4]), .session_active(o0[3]), .warn(o0[2]),
      .session_abort(o0[1]), .eject_req(o0[0])
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
      , .abort_count(cnt0)
`endif
   );

   atm_session_guard #(.WARN_LIMIT(2'd2)) dut2 (
      .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid),
      .session_done(session_done), .timeout(timeout),
      .tmr_start(o2[5]), .tmr_restart(o2[4]), .session_active(o2[3]), .warn(o2[2]),
      .session_abort(o2[1]), .eject_req(o2[0])
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
      , .abort_count(cnt2)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      card_in = 0; key_valid = 0; session_done = 0; timeout = 0;
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL reset: got %b want %b", o1, IDLE); end
      total++; if (o0 !== IDLE) begin bad++; $display("FAIL reset0: got %b want %b", o0, IDLE); end
      card_in = 1;
      tick();
      total++; if (o1 !== ACT) begin bad++; $display("FAIL start: got %b want %b", o1, ACT); end
   endtask

   task automatic test_key();
      key_valid = 1;
      #1;
      total++; if (o1 !== ACT_K) begin bad++; $display("FAIL key_comb: got %b want %b", o1, ACT_K); end
      tick();
      key_valid = 0;
      #1;
      total++; if (o1 !== ACT) begin bad++; $display("FAIL key_stay: got %b want %b", o1, ACT); end
   endtask

   task automatic test_warn();
      timeout = 1;
      tick();
      total++; if (o1 !== REARM) begin bad++; $display("FAIL rearm: got %b want %b", o1, REARM); end
      timeout = 0;
      tick();
      total++; if (o1 !== WARN) begin bad++; $display("FAIL warn: got %b want %b", o1, WARN); end
      key_valid = 1;
      #1;
      total++; if (o1 !== WARN_K) begin bad++; $display("FAIL warn_key: got %b want %b", o1, WARN_K); end
      tick();
      key_valid = 0;
      #1;
      total++; if (o1 !== ACT) begin bad++; $display("FAIL resume: got %b want %b", o1, ACT); end
      // Counter was cleared by the key, so this timeout warns rather than aborts.
      timeout = 1;
      tick();
      total++; if (o1 !== REARM) begin bad++; $display("FAIL rearm2: got %b want %b", o1, REARM); end
      timeout = 0;
      tick();
      total++; if (o1 !== WARN) begin bad++; $display("FAIL warn2: got %b want %b", o1, WARN); end
   endtask

   task automatic test_abort();
      timeout = 1;
      tick();
      total++; if (o1 !== ABRT) begin bad++; $display("FAIL abort: got %b want %b", o1, ABRT); end
      timeout = 0;
      tick();
      total++; if (o1 !== EJCT) begin bad++; $display("FAIL eject: got %b want %b", o1, EJCT); end
      key_valid = 1; session_done = 1; timeout = 1;
      tick();
      key_valid = 0; session_done = 0; timeout = 0;
      #1;
      total++; if (o1 !== EJCT) begin bad++; $display("FAIL eject_hold: got %b want %b", o1, EJCT); end
      card_in = 0;
      tick();
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL eject_exit: got %b want %b", o1, IDLE); end
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
      total++; if (cnt1 !== 8'd1) begin bad++; $display("FAIL abort_count: got %0d want 1", cnt1); end
`endif
   endtask

   task automatic test_simultaneous();
      do_reset();
      card_in = 1;
      tick();
      timeout = 1;
      tick();
      timeout = 0;
      tick();
      total++; if (o2 !== WARN) begin bad++; $display("FAIL sim_warn: got %b want %b", o2, WARN); end
      timeout = 1; key_valid = 1;
      #1;
      total++; if (o2 !== WARN_K) begin bad++; $display("FAIL sim_rst: got %b want %b", o2, WARN_K); end
      tick();
      total++; if (o2 !== REARM) begin bad++; $display("FAIL sim_rearm: got %b want %b", o2, REARM); end
      timeout = 0; key_valid = 0;
      tick();
      // warn_cnt reached 2 on the simultaneous event, so the next timeout aborts.
      timeout = 1;
      tick();
      timeout = 0;
      #1;
      total++; if (o2 !== ABRT) begin bad++; $display("FAIL sim_abort: got %b want %b", o2, ABRT); end
   endtask

   task automatic test_card_drop();
      do_reset();
      card_in = 1;
      tick();
      card_in = 0;
      tick();
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL drop: got %b want %b", o1, IDLE); end
      card_in = 1;
      tick();
      session_done = 1;
      tick();
      session_done = 0;
      #1;
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL done: got %b want %b", o1, IDLE); end
      tick();
      timeout = 1;
      tick();
      card_in = 0; timeout = 0;
      tick();
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL rearm_drop: got %b want %b", o1, IDLE); end
   endtask

   task automatic test_reset_in_warn();
      do_reset();
      card_in = 1;
      tick();
      timeout = 1;
      tick();
      timeout = 0;
      tick();
      rst = 0;
      #1;
      total++; if (o1 !== WARN) begin bad++; $display("FAIL sync_rst: got %b want %b", o1, WARN); end
      tick();
      total++; if (o1 !== IDLE) begin bad++; $display("FAIL rst_warn: got %b want %b", o1, IDLE); end
      rst = 1;
   endtask

   task automatic test_limit0();
      do_reset();
      card_in = 1;
      tick();
      timeout = 1;
      tick();
      total++; if (o0 !== ABRT) begin bad++; $display("FAIL lim0_abort: got %b want %b", o0, ABRT); end
      total++; if (o1 !== REARM) begin bad++; $display("FAIL lim1_rearm: got %b want %b", o1, REARM); end
      timeout = 0;
      tick();
      total++; if (o0 !== EJCT) begin bad++; $display("FAIL lim0_eject: got %b want %b", o0, EJCT); end
`ifdef ATM_SESSION_GUARD_ABORT_COUNT_EN
      total++; if (cnt0 !== 8'd1) begin bad++; $display("FAIL lim0_count: got %0d want 1", cnt0); end
`endif
   endtask

   initial begin
      test_reset();
      test_key();
      test_warn();
      test_abort();
      test_simultaneous();
      test_card_drop();
      test_reset_in_warn();
      test_limit0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
